// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package adder_pkg;

   // One (G,P) pair per bit; vectors are pg_t [WIDTH-1:0].
   typedef struct packed {
      logic g;
      logic p;
   } pg_t;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

   function automatic int nstages(input int levels, input int sl);
      int n;
      n = (levels + sl - 1) / sl;
      return (n < 1) ? 1 : n;
   endfunction

   function automatic int stage_lo(input int s, input int sl);
      return s * sl;
   endfunction

   function automatic int stage_hi(input int s, input int sl, input int levels);
      int hi;
      hi = s * sl + sl;
      if (hi > levels) hi = levels;
      return hi - 1;
   endfunction

endpackage

// File: rtl/adder_ks_stage.sv
// Prefix levels LO..HI followed by one elastic register slot.
module adder_ks_stage
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LO    = 0,
   parameter int HI    = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   v_i,
   output logic                   rdy_o,
   input  pg_t [WIDTH-1:0]        pg_i,
   input  logic [WIDTH-1:0]       p_i,
   input  logic                   c0_i,
   output logic                   v_o,
   input  logic                   rdy_i,
   output pg_t [WIDTH-1:0]        pg_o,
   output logic [WIDTH-1:0]       p_o,
   output logic                   c0_o
);

   logic             v_q;
   pg_t [WIDTH-1:0]  pg_d, pg_q;
   logic [WIDTH-1:0] p_q;
   logic             c0_q;
   logic             adv;

   always_comb begin
      pg_t [WIDTH-1:0] cur;
      pg_t [WIDTH-1:0] nxt;
      cur = pg_i;
      for (int k = LO; k <= HI; k++) begin
         nxt = cur;
         // Bits below the lookback distance pass straight through.
         for (int i = (1 << k); i < WIDTH; i++) begin
            nxt[i].g = cur[i].g | (cur[i].p & cur[i-(1<<k)].g);
            nxt[i].p = cur[i].p & cur[i-(1<<k)].p;
         end
         cur = nxt;
      end
      pg_d = cur;
   end

   assign adv   = !v_q || rdy_i;
   assign rdy_o = adv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q  <= 1'b0;
         pg_q <= '0;
         p_q  <= '0;
         c0_q <= 1'b0;
      end else if (adv) begin
         v_q <= v_i;
         if (v_i) begin
            pg_q <= pg_d;
            p_q  <= p_i;
            c0_q <= c0_i;
         end
      end
   end

   assign v_o  = v_q;
   assign pg_o = pg_q;
   assign p_o  = p_q;
   assign c0_o = c0_q;

endmodule

// File: rtl/adder_ks_pipe.sv
// Pipelined Kogge-Stone add/sub with valid/ready on both sides.
// ADDER_KS_PIPE_FLAGS_EN adds out_zero/out_neg result flags.
module adder_ks_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int STAGE_LEVELS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
`ifdef ADDER_KS_PIPE_FLAGS_EN
   ,
   output logic             out_zero,
   output logic             out_neg
`endif
);

   localparam int LEVELS  = clog2(WIDTH);
   localparam int NSTAGES = nstages(LEVELS, STAGE_LEVELS);

   logic [WIDTH-1:0] b_eff, p0, g0;
   logic             c0;
   pg_t [WIDTH-1:0]  pg0;

   always_comb begin
      b_eff = sub ? ~b : b;
      c0    = sub ? 1'b1 : cin;
      p0    = a ^ b_eff;
      g0    = a & b_eff;
      for (int i = 0; i < WIDTH; i++) begin
         pg0[i].g = g0[i];
         pg0[i].p = p0[i];
      end
      // Carry-in becomes part of bit 0's generate.
      pg0[0].g = g0[0] | (p0[0] & c0);
   end

   for (genvar s = 0; s < NSTAGES; s++) begin : g_stg
      logic             v_in, rdy_in, v, rdy;
      pg_t [WIDTH-1:0]  pg_in, pg;
      logic [WIDTH-1:0] p_in, p;
      logic             c0_in, c0q;

      if (s == 0) begin : g_src
         assign v_in  = in_valid;
         assign pg_in = pg0;
         assign p_in  = p0;
         assign c0_in = c0;
      end else begin : g_mid
         assign v_in  = g_stg[s-1].v;
         assign pg_in = g_stg[s-1].pg;
         assign p_in  = g_stg[s-1].p;
         assign c0_in = g_stg[s-1].c0q;
      end

      if (s == NSTAGES - 1) begin : g_end
         assign rdy_in = out_ready;
      end else begin : g_fwd
         assign rdy_in = g_stg[s+1].rdy;
      end

      adder_ks_stage #(
         .WIDTH (WIDTH),
         .LO    (stage_lo(s, STAGE_LEVELS)),
         .HI    (stage_hi(s, STAGE_LEVELS, LEVELS))
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .v_i   (v_in),
         .rdy_o (rdy),
         .pg_i  (pg_in),
         .p_i   (p_in),
         .c0_i  (c0_in),
         .v_o   (v),
         .rdy_i (rdy_in),
         .pg_o  (pg),
         .p_o   (p),
         .c0_o  (c0q)
      );
   end

   pg_t [WIDTH-1:0]  pg_l;
   logic [WIDTH-1:0] p_l, g_l, p_pref;
   logic             c0_l;
   logic             unused_pref;

   assign pg_l      = g_stg[NSTAGES-1].pg;
   assign p_l       = g_stg[NSTAGES-1].p;
   assign c0_l      = g_stg[NSTAGES-1].c0q;
   assign out_valid = g_stg[NSTAGES-1].v;
   assign in_ready  = g_stg[0].rdy;

   // Post-processing reads only the last register, so it holds under stall.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         g_l[i]    = pg_l[i].g;
         p_pref[i] = pg_l[i].p;
      end
      sum  = p_l ^ {g_l[WIDTH-2:0], c0_l};
      cout = g_l[WIDTH-1];
      ovf  = g_l[WIDTH-1] ^ g_l[WIDTH-2];
   end

   assign unused_pref = ^p_pref;

`ifdef ADDER_KS_PIPE_FLAGS_EN
   assign out_zero = out_valid & (sum == '0);
   assign out_neg  = out_valid & sum[WIDTH-1];
`endif

endmodule

// File: tb/tb_adder_ks_pipe.sv
// Directed bench for adder_ks_pipe at WIDTH=32, STAGE_LEVELS=2.
module tb_adder_ks_pipe;

   localparam int W    = 32;
   localparam int NOPS = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
`ifdef ADDER_KS_PIPE_FLAGS_EN
   logic         out_zero;
   logic         out_neg;
`endif

   int nvec = 0;
   int nerr = 0;
   int nxt  = 0;
   int acc  = 0;
   int dlv  = 0;
   logic [W+1:0] q[$];

   logic [W-1:0] ta [NOPS] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0000,
                               32'h1234_5678, 32'hFFFF_0000, 32'h0F0F_0F0F,
                               32'h7FFF_FFFF, 32'h0000_0000, 32'hAAAA_AAAA,
                               32'h5555_5555};
   logic [W-1:0] tb_ [NOPS] = '{32'h0000_0002, 32'h1111_1111, 32'h8000_0000,
                                32'h1234_5678, 32'h0001_0000, 32'hF0F0_F0F0,
                                32'hFFFF_FFFF, 32'h0000_0001, 32'h5555_5555,
                                32'hAAAA_AAAB};
   logic         tc [NOPS] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                               1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic         ts [NOPS] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   adder_ks_pipe #(
      .WIDTH        (W),
      .STAGE_LEVELS (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
`ifdef ADDER_KS_PIPE_FLAGS_EN
      ,
      .out_zero  (out_zero),
      .out_neg   (out_neg)
`endif
   );

   // Returns {ovf, cout, sum} from plain wide arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic c,
                                          input logic s);
      logic [W-1:0] be;
      logic         c0;
      logic [W:0]   full;
      logic [W-1:0] low;
      be   = s ? ~y : y;
      c0   = s ? 1'b1 : c;
      full = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, c0};
      low  = {1'b0, x[W-2:0]} + {1'b0, be[W-2:0]} + {{(W-1){1'b0}}, c0};
      return {full[W] ^ low[W-1], full[W], full[W-1:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic op1(input string tag, input logic [W-1:0] xa,
                      input logic [W-1:0] xb, input logic xc, input logic xs,
                      input logic [W-1:0] es, input logic ec, input logic eo);
      int n;
      a = xa; b = xb; cin = xc; sub = xs;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk({tag, ".rdy"}, 64'(in_ready), 64'(1'b1));
      n = 0;
      do begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         n++;
      end while (!out_valid && n < 10);
      chk({tag, ".lat"}, 64'(n), 64'(3));
      chk({tag, ".sum"}, 64'(sum), 64'(es));
      chk({tag, ".cout"}, 64'(cout), 64'(ec));
      chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
      @(posedge clk); #1;
      chk({tag, ".done"}, 64'(out_valid), 64'(1'b0));
   endtask

   task automatic step(input logic iv, input logic ordy);
      logic fi, fo;
      in_valid = iv && (nxt < NOPS);
      if (nxt < NOPS) begin
         a = ta[nxt]; b = tb_[nxt]; cin = tc[nxt]; sub = ts[nxt];
      end
      out_ready = ordy;
      #1;
      fi = in_valid & in_ready;
      fo = out_valid & out_ready;
      if (out_valid) begin
         chk("bp.q", 64'(q.size() > 0), 64'(1'b1));
         if (q.size() > 0)
            chk("bp.data", 64'({ovf, cout, sum}), 64'(q[0]));
      end
      @(posedge clk); #1;
      if (fi) begin
         q.push_back(model(ta[nxt], tb_[nxt], tc[nxt], ts[nxt]));
         nxt++;
         acc++;
      end
      if (fo) begin
         void'(q.pop_front());
         dlv++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [W+1:0] e;
      logic         ev;

      // reset with in_valid high
      rst_n = 1'b0; in_valid = 1'b1; a = 32'h1; b = 32'h2;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.vld", 64'(out_valid), 64'(1'b0));
      chk("rst.sum", 64'(sum), 64'(0));
      chk("rst.cout", 64'(cout), 64'(1'b0));
      chk("rst.ovf", 64'(ovf), 64'(1'b0));
      in_valid = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst.rdy", 64'(in_ready), 64'(1'b1));
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst.idle", 64'(out_valid), 64'(1'b0));
      end

      // directed add / sub
      op1("add.chain", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      op1("add.ovf", 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      op1("add.cin", 32'h3, 32'h4, 1'b1, 1'b0, 32'h8, 1'b0, 1'b0);
      op1("sub.neg", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      op1("sub.ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      op1("sub.eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);

      // streaming, one op per cycle
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c < 8) begin
            a = ta[c]; b = tb_[c]; cin = tc[c]; sub = ts[c];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c < 8) chk("st.rdy", 64'(in_ready), 64'(1'b1));
         @(posedge clk); #1;
         ev = (c >= 2 && c <= 9);
         chk("st.vld", 64'(out_valid), 64'(ev));
         if (ev) begin
            e = model(ta[c-2], tb_[c-2], tc[c-2], ts[c-2]);
            chk("st.res", 64'({ovf, cout, sum}), 64'(e));
         end
      end

      // backpressure
      nxt = 0; acc = 0; dlv = 0;
      repeat (5) step(1'b1, 1'b0);
      chk("bp.acc3", 64'(acc), 64'(3));
      in_valid = 1'b1; out_ready = 1'b0;
      #1;
      chk("bp.full", 64'(in_ready), 64'(1'b0));
      chk("bp.hold", 64'(out_valid), 64'(1'b1));
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      chk("bp.bubble", 64'(acc), 64'(4));
      step(1'b1, 1'b0);
      chk("bp.stall", 64'(acc), 64'(4));
      for (int i = 0; i < 8; i++) step(1'b1, (i % 2) == 0);
      for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 1'b1);
      chk("bp.drain", 64'(q.size()), 64'(0));
      chk("bp.count", 64'(dlv), 64'(acc));
      chk("bp.idle", 64'(out_valid), 64'(1'b0));

      // reset with two ops in flight
      out_ready = 1'b1;
      a = ta[1]; b = tb_[1]; cin = tc[1]; sub = ts[1]; in_valid = 1'b1;
      @(posedge clk); #1;
      a = ta[2]; b = tb_[2]; cin = tc[2]; sub = ts[2];
      @(posedge clk); #1;
      in_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid.vld", 64'(out_valid), 64'(1'b0));
      chk("mid.sum", 64'(sum), 64'(0));
      repeat (4) begin
         @(posedge clk); #1;
         chk("mid.stale", 64'(out_valid), 64'(1'b0));
      end
      op1("mid.new", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
